// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit: FSM state encoding,
// forwarding-select codes and the default register-address width.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } hcu_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int DEF_REG_ADDR_W = 5;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline <-> hazard control unit signal bundle.
// master: pipeline side (drives stage info, receives controls).
// slave : hazard control unit.
interface hazard_control_unit_if #(
    parameter int REG_ADDR_W = hazard_pkg::DEF_REG_ADDR_W
);
    logic [REG_ADDR_W-1:0] if_id_rs1_addr;
    logic [REG_ADDR_W-1:0] if_id_rs2_addr;
    logic                  if_id_uses_rs1;
    logic                  if_id_uses_rs2;
    logic [REG_ADDR_W-1:0] id_ex_rs1_addr;
    logic [REG_ADDR_W-1:0] id_ex_rs2_addr;
    logic [REG_ADDR_W-1:0] id_ex_rd_addr;
    logic                  id_ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_mem_rd_addr;
    logic                  ex_mem_reg_write;
    logic                  ex_mem_mem_access;
    logic [REG_ADDR_W-1:0] mem_wb_rd_addr;
    logic                  mem_wb_reg_write;
    logic                  branch_taken;
    logic                  dmem_ready;
    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  id_ex_bubble;
    logic                  if_id_flush;
    logic                  pipe_hold;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;

    modport master (
        output if_id_rs1_addr, if_id_rs2_addr, if_id_uses_rs1, if_id_uses_rs2,
               id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr, id_ex_mem_read,
               ex_mem_rd_addr, ex_mem_reg_write, ex_mem_mem_access,
               mem_wb_rd_addr, mem_wb_reg_write, branch_taken, dmem_ready,
        input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush, pipe_hold,
               fwd_a_sel, fwd_b_sel
    );

    modport slave (
        input  if_id_rs1_addr, if_id_rs2_addr, if_id_uses_rs1, if_id_uses_rs2,
               id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr, id_ex_mem_read,
               ex_mem_rd_addr, ex_mem_reg_write, ex_mem_mem_access,
               mem_wb_rd_addr, mem_wb_reg_write, branch_taken, dmem_ready,
        output pc_stall, if_id_stall, id_ex_bubble, if_id_flush, pipe_hold,
               fwd_a_sel, fwd_b_sel
    );
endinterface

// File: rtl/hazard_control_unit_forwarding_unit.sv
// EX operand forwarding selects. Purely combinational; EX/MEM wins over
// MEM/WB, and register x0 never forwards.
module forwarding_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_ex_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_ex_rs2_addr,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd_addr,
    input  logic                  ex_mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd_addr,
    input  logic                  mem_wb_reg_write,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel
);

    function automatic logic [1:0] pick_src(input logic [REG_ADDR_W-1:0] rs);
        if (ex_mem_reg_write && (ex_mem_rd_addr != '0) && (ex_mem_rd_addr == rs))
            return FWD_EXMEM;
        else if (mem_wb_reg_write && (mem_wb_rd_addr != '0) && (mem_wb_rd_addr == rs))
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    // One independent selection per EX operand
    always_comb begin
        fwd_a_sel = pick_src(id_ex_rs1_addr);
        fwd_b_sel = pick_src(id_ex_rs2_addr);
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control unit: load-use stall sequencing, branch flush sequencing,
// data-memory wait hold and EX forwarding selects. All controls are
// combinational from current state and stage inputs (zero added latency).
// Optional build macro HAZARD_PERF_CNT_EN adds three 32-bit event counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
    parameter int LOAD_USE_STALL = 1,
    parameter int FLUSH_CYCLES   = 1,
    parameter int CNT_W          = 3
) (
    input  logic                clk,
    input  logic                rst,
    hazard_control_unit_if.slave hif
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]         perf_lu_stalls,
    output logic [31:0]         perf_flushes,
    output logic [31:0]         perf_mem_waits
`endif
);

    hcu_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             lu_hit, mem_hold;
    logic             stall_o, flush_o, bubble_o, hold_o;
    logic [1:0]       fwd_a_raw, fwd_b_raw;

    forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
        .id_ex_rs1_addr   (hif.id_ex_rs1_addr),
        .id_ex_rs2_addr   (hif.id_ex_rs2_addr),
        .ex_mem_rd_addr   (hif.ex_mem_rd_addr),
        .ex_mem_reg_write (hif.ex_mem_reg_write),
        .mem_wb_rd_addr   (hif.mem_wb_rd_addr),
        .mem_wb_reg_write (hif.mem_wb_reg_write),
        .fwd_a_sel        (fwd_a_raw),
        .fwd_b_sel        (fwd_b_raw)
    );

    // Hazard conditions seen this cycle
    always_comb begin
        lu_hit = hif.id_ex_mem_read && (hif.id_ex_rd_addr != '0) &&
                 ((hif.if_id_uses_rs1 && (hif.if_id_rs1_addr == hif.id_ex_rd_addr)) ||
                  (hif.if_id_uses_rs2 && (hif.if_id_rs2_addr == hif.id_ex_rd_addr)));
        mem_hold = hif.ex_mem_mem_access && !hif.dmem_ready;
    end

    // Control outputs and next state; priority rst > memory wait > branch > load-use
    always_comb begin
        stall_o  = 1'b0;
        flush_o  = 1'b0;
        bubble_o = 1'b0;
        hold_o   = 1'b0;
        state_n  = state;
        cnt_n    = cnt;
        if (rst) begin
            state_n = RUN;
            cnt_n   = '0;
        end else if (mem_hold) begin
            // Freeze the sequence; only an idle pipeline is marked as waiting
            hold_o = 1'b1;
            if (state == RUN)
                state_n = MEM_WAIT;
        end else begin
            case (state)
                RUN, MEM_WAIT: begin
                    state_n = RUN;
                    cnt_n   = '0;
                    if (hif.branch_taken) begin
                        flush_o  = 1'b1;
                        bubble_o = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_n = FLUSH;
                            cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
                        end
                    end else if (lu_hit) begin
                        stall_o  = 1'b1;
                        bubble_o = 1'b1;
                        if (LOAD_USE_STALL > 1) begin
                            state_n = LU_STALL;
                            cnt_n   = CNT_W'(LOAD_USE_STALL - 1);
                        end
                    end
                end
                LU_STALL: begin
                    if (hif.branch_taken) begin
                        // A taken branch kills the stalled instruction anyway
                        flush_o  = 1'b1;
                        bubble_o = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_n = FLUSH;
                            cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
                        end else begin
                            state_n = RUN;
                            cnt_n   = '0;
                        end
                    end else begin
                        stall_o  = 1'b1;
                        bubble_o = 1'b1;
                        if (cnt <= CNT_W'(1)) begin
                            state_n = RUN;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt - CNT_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    flush_o  = 1'b1;
                    bubble_o = 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // State and down-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Drive the bundle; forwarding is forced to the register file during reset and hold
    always_comb begin
        hif.pc_stall     = stall_o;
        hif.if_id_stall  = stall_o;
        hif.id_ex_bubble = bubble_o;
        hif.if_id_flush  = flush_o;
        hif.pipe_hold    = hold_o;
        hif.fwd_a_sel    = (rst || mem_hold) ? FWD_RF : fwd_a_raw;
        hif.fwd_b_sel    = (rst || mem_hold) ? FWD_RF : fwd_b_raw;
    end

`ifdef HAZARD_PERF_CNT_EN
    // Event counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_stalls <= '0;
            perf_flushes   <= '0;
            perf_mem_waits <= '0;
        end else begin
            if (stall_o) perf_lu_stalls <= perf_lu_stalls + 32'd1;
            if (flush_o) perf_flushes   <= perf_flushes + 32'd1;
            if (hold_o)  perf_mem_waits <= perf_mem_waits + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: dut_a uses default stall/flush lengths
// (stateless behaviour, table-driven), dut_b uses LOAD_USE_STALL=3 and
// FLUSH_CYCLES=2 for the multi-cycle sequences.
module tb_hazard_control_unit;
    import hazard_pkg::*;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       mem_read;
        logic [4:0] exm_rd;
        logic       exm_wr;
        logic       exm_acc;
        logic [4:0] wb_rd;
        logic       wb_wr;
        logic       br;
        logic       rdy;
    } in_t;

    typedef struct {
        in_t        in;
        logic [8:0] exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    hazard_control_unit_if #(.REG_ADDR_W(5)) if_a ();
    hazard_control_unit_if #(.REG_ADDR_W(5)) if_b ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] pa_lu, pa_fl, pa_mw, pb_lu, pb_fl, pb_mw;
`endif

    hazard_control_unit #(.REG_ADDR_W(5), .LOAD_USE_STALL(1), .FLUSH_CYCLES(1), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst), .hif(if_a)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_lu_stalls(pa_lu), .perf_flushes(pa_fl), .perf_mem_waits(pa_mw)
`endif
    );

    hazard_control_unit #(.REG_ADDR_W(5), .LOAD_USE_STALL(3), .FLUSH_CYCLES(2), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .hif(if_b)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_lu_stalls(pb_lu), .perf_flushes(pb_fl), .perf_mem_waits(pb_mw)
`endif
    );

    // {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, pipe_hold, fwd_a, fwd_b}
    wire [8:0] out_a = {if_a.pc_stall, if_a.if_id_stall, if_a.id_ex_bubble,
                        if_a.if_id_flush, if_a.pipe_hold, if_a.fwd_a_sel, if_a.fwd_b_sel};
    wire [8:0] out_b = {if_b.pc_stall, if_b.if_id_stall, if_b.id_ex_bubble,
                        if_b.if_id_flush, if_b.pipe_hold, if_b.fwd_a_sel, if_b.fwd_b_sel};

    task automatic apply(input in_t v);
        if_a.if_id_rs1_addr = v.rs1;    if_b.if_id_rs1_addr = v.rs1;
        if_a.if_id_rs2_addr = v.rs2;    if_b.if_id_rs2_addr = v.rs2;
        if_a.if_id_uses_rs1 = v.use1;   if_b.if_id_uses_rs1 = v.use1;
        if_a.if_id_uses_rs2 = v.use2;   if_b.if_id_uses_rs2 = v.use2;
        if_a.id_ex_rs1_addr = v.ex_rs1; if_b.id_ex_rs1_addr = v.ex_rs1;
        if_a.id_ex_rs2_addr = v.ex_rs2; if_b.id_ex_rs2_addr = v.ex_rs2;
        if_a.id_ex_rd_addr  = v.ex_rd;  if_b.id_ex_rd_addr  = v.ex_rd;
        if_a.id_ex_mem_read = v.mem_read; if_b.id_ex_mem_read = v.mem_read;
        if_a.ex_mem_rd_addr = v.exm_rd; if_b.ex_mem_rd_addr = v.exm_rd;
        if_a.ex_mem_reg_write  = v.exm_wr;  if_b.ex_mem_reg_write  = v.exm_wr;
        if_a.ex_mem_mem_access = v.exm_acc; if_b.ex_mem_mem_access = v.exm_acc;
        if_a.mem_wb_rd_addr   = v.wb_rd; if_b.mem_wb_rd_addr   = v.wb_rd;
        if_a.mem_wb_reg_write = v.wb_wr; if_b.mem_wb_reg_write = v.wb_wr;
        if_a.branch_taken = v.br;  if_b.branch_taken = v.br;
        if_a.dmem_ready   = v.rdy; if_b.dmem_ready   = v.rdy;
    endtask

    // Advance to the next cycle, drive inputs, then settle at the falling edge
    task automatic drive(input in_t v);
        @(posedge clk);
        #1;
        apply(v);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t tbl[12];
    in_t  idle, lu, v;

    initial begin
        idle = '0;
        idle.rdy = 1'b1;
        lu = idle;
        lu.mem_read = 1'b1; lu.ex_rd = 5'd5; lu.rs1 = 5'd5; lu.use1 = 1'b1;

        // Single-cycle vectors for dut_a (stall/flush length 1)
        tbl[0].in = lu; tbl[0].exp = 9'b11100_00_00; tbl[0].name = "lu_rs1";
        v = lu; v.ex_rd = 5'd0; v.rs1 = 5'd0;
        tbl[1].in = v;  tbl[1].exp = 9'b00000_00_00; tbl[1].name = "lu_rd0";
        v = idle; v.mem_read = 1'b1; v.ex_rd = 5'd5; v.rs2 = 5'd5; v.use2 = 1'b1;
        tbl[2].in = v;  tbl[2].exp = 9'b11100_00_00; tbl[2].name = "lu_rs2";
        v = lu; v.use1 = 1'b0;
        tbl[3].in = v;  tbl[3].exp = 9'b00000_00_00; tbl[3].name = "lu_nouse";
        v = idle; v.exm_rd = 5'd7; v.exm_wr = 1'b1; v.wb_rd = 5'd7; v.wb_wr = 1'b1; v.ex_rs1 = 5'd7;
        tbl[4].in = v;  tbl[4].exp = 9'b00000_10_00; tbl[4].name = "fwd_exmem";
        v.exm_wr = 1'b0;
        tbl[5].in = v;  tbl[5].exp = 9'b00000_01_00; tbl[5].name = "fwd_memwb";
        v = idle; v.exm_wr = 1'b1; v.wb_wr = 1'b1;
        tbl[6].in = v;  tbl[6].exp = 9'b00000_00_00; tbl[6].name = "fwd_x0";
        v = idle; v.ex_rs1 = 5'd3; v.exm_rd = 5'd3; v.exm_wr = 1'b1;
        v.ex_rs2 = 5'd9; v.wb_rd = 5'd9; v.wb_wr = 1'b1;
        tbl[7].in = v;  tbl[7].exp = 9'b00000_10_01; tbl[7].name = "fwd_both";
        v = lu; v.br = 1'b1;
        tbl[8].in = v;  tbl[8].exp = 9'b00110_00_00; tbl[8].name = "br_over_lu";
        v = lu; v.exm_acc = 1'b1; v.rdy = 1'b0; v.ex_rs1 = 5'd7; v.exm_rd = 5'd7; v.exm_wr = 1'b1;
        tbl[9].in = v;  tbl[9].exp = 9'b00001_00_00; tbl[9].name = "mem_hold";
        v.rdy = 1'b1;
        tbl[10].in = v; tbl[10].exp = 9'b11100_10_00; tbl[10].name = "mem_ready";
        v = idle; v.rdy = 1'b0; v.ex_rs2 = 5'd4; v.wb_rd = 5'd4; v.wb_wr = 1'b1;
        tbl[11].in = v; tbl[11].exp = 9'b00000_00_01; tbl[11].name = "rdy_low_noacc";

        // Reset: outputs forced low even with a hazard and forwarding match present
        v = lu; v.ex_rs1 = 5'd7; v.exm_rd = 5'd7; v.exm_wr = 1'b1;
        apply(v);
        @(negedge clk);
        chk("rst_outs_a", {23'd0, out_a}, 32'd0);
        chk("rst_outs_b", {23'd0, out_b}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(idle);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].in);
            chk(tbl[i].name, {23'd0, out_a}, {23'd0, tbl[i].exp});
        end

        // Fresh start for dut_b
        @(posedge clk); #1; rst = 1'b1; apply(idle);
        @(posedge clk); #1; rst = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        chk("perf_lu_rst", pb_lu, 32'd0);
        chk("perf_fl_rst", pb_fl, 32'd0);
        chk("perf_mw_rst", pb_mw, 32'd0);
`endif

        // Load-use with a 3-cycle stall
        drive(lu);   chk("lu3_c0", {29'd0, out_b[8:6]}, 32'd7);
        drive(idle); chk("lu3_c1", {29'd0, out_b[8:6]}, 32'd7);
        drive(idle); chk("lu3_c2", {29'd0, out_b[8:6]}, 32'd7);
        drive(idle); chk("lu3_c3", {29'd0, out_b[8:6]}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_lu_3", pb_lu, 32'd3);
`endif
        v = lu; v.ex_rd = 5'd0; v.rs1 = 5'd0;
        drive(v);    chk("lu3_rd0", {23'd0, out_b}, 32'd0);

        // Branch with 2 flush cycles, concurrent load-use discarded
        v = lu; v.br = 1'b1;
        drive(v);    chk("br2_c0", {23'd0, out_b}, {23'd0, 9'b00110_00_00});
        drive(idle); chk("br2_c1", {23'd0, out_b}, {23'd0, 9'b00110_00_00});
        drive(idle); chk("br2_c2", {23'd0, out_b}, 32'd0);

        // Memory wait in the middle of a load-use stall (cnt = 2)
        drive(lu);   chk("mw_c0", {29'd0, out_b[8:6]}, 32'd7);
        v = idle; v.exm_acc = 1'b1; v.rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(v);
            chk($sformatf("mw_hold%0d", k), {23'd0, out_b}, {23'd0, 9'b00001_00_00});
        end
        v.rdy = 1'b1;
        drive(v);    chk("mw_res1", {23'd0, out_b}, {23'd0, 9'b11100_00_00});
        drive(idle); chk("mw_res2", {23'd0, out_b}, {23'd0, 9'b11100_00_00});
        drive(idle); chk("mw_done", {23'd0, out_b}, 32'd0);

        // Reset in the middle of a load-use stall
        drive(lu);   chk("rs_c0", {29'd0, out_b[8:6]}, 32'd7);
        @(posedge clk); #1; rst = 1'b1; apply(lu);
        @(negedge clk);
        chk("rs_during", {23'd0, out_b}, 32'd0);
        drive(idle);
        rst = 1'b0;
        @(negedge clk);
        chk("rs_after", {23'd0, out_b}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_lu_rst2", pb_lu, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench always terminates
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Parametrised successor to the single-signal load-use detector in the 5-stage pipelined core.
- Combines four functions in one block:
  - load-use detection with a configurable stall length;
  - EX operand forwarding selects;
  - branch/jump flush sequencing;
  - a global pipeline hold while data memory is not ready.
- Sits beside the pipeline registers and drives every stall, flush and bubble control in the core.

Parameters:
- REG_ADDR_W, 5, register-address width (32 architectural registers).
- LOAD_USE_STALL, 1, bubble cycles inserted per load-use hazard (range 1..7).
- FLUSH_CYCLES, 1, cycles IF/ID and ID/EX are flushed after a taken branch (range 1..3).
- CNT_W, 3, width of the internal stall/flush down-counter (must satisfy 2^CNT_W > max(LOAD_USE_STALL, FLUSH_CYCLES)).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_id_rs1_addr  in  REG_ADDR_W  rs1 of the instruction in ID.
- if_id_rs2_addr  in  REG_ADDR_W  rs2 of the instruction in ID.
- if_id_uses_rs1  in  1  ID instruction reads rs1.
- if_id_uses_rs2  in  1  ID instruction reads rs2.
- id_ex_rs1_addr  in  REG_ADDR_W  rs1 of the instruction in EX (forwarding).
- id_ex_rs2_addr  in  REG_ADDR_W  rs2 of the instruction in EX (forwarding).
- id_ex_rd_addr  in  REG_ADDR_W  rd of the instruction in EX.
- id_ex_mem_read  in  1  EX instruction is a load.
- ex_mem_rd_addr  in  REG_ADDR_W  rd in MEM.
- ex_mem_reg_write  in  1  MEM instruction writes rd.
- ex_mem_mem_access  in  1  MEM instruction is a load or store.
- mem_wb_rd_addr  in  REG_ADDR_W  rd in WB.
- mem_wb_reg_write  in  1  WB instruction writes rd.
- branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- id_ex_bubble  out  1  load NOP into ID/EX.
- if_id_flush  out  1  clear IF/ID to NOP.
- pipe_hold  out  1  freeze every pipeline register (memory wait).
- fwd_a_sel  out  2  EX operand A source: 00 register file, 10 EX/MEM, 01 MEM/WB.
- fwd_b_sel  out  2  EX operand B source: same encoding as fwd_a_sel.

Behaviour:
- Register x0: an address of 0 never matches for hazard or forwarding purposes.
- Load-use hit (lu_hit): id_ex_mem_read AND rd != 0 AND ((if_id_uses_rs1 AND rs1 == rd) OR (if_id_uses_rs2 AND rs2 == rd)).
- Forwarding, fully combinational, one rule per operand:
  - select 10 if ex_mem_reg_write AND ex_mem_rd != 0 AND ex_mem_rd == id_ex_rsN;
  - else 01 if the equivalent MEM/WB match holds;
  - else 00.
  - EX/MEM has priority over MEM/WB.
- FSM states: RUN, LU_STALL, FLUSH, MEM_WAIT. The counter cnt is CNT_W bits wide.
- Priority on each cycle: rst > memory wait > branch_taken > lu_hit.
- Memory wait: ex_mem_mem_access AND NOT dmem_ready forces pipe_hold = 1 combinationally.
  - While pipe_hold is high, all other outputs are 0, and state and cnt are frozen.
  - The state shows MEM_WAIT on the next edge only if it was RUN.
  - Return to RUN on the first cycle dmem_ready = 1.
- RUN with branch_taken:
  - if_id_flush = 1 and id_ex_bubble = 1 in the same cycle.
  - If FLUSH_CYCLES > 1: go to FLUSH with cnt = FLUSH_CYCLES - 1.
  - Any concurrent lu_hit is discarded.
- RUN with lu_hit:
  - pc_stall = if_id_stall = id_ex_bubble = 1 in the detection cycle.
  - If LOAD_USE_STALL > 1: go to LU_STALL with cnt = LOAD_USE_STALL - 1.
- LU_STALL:
  - Same three outputs asserted; cnt decrements each cycle; leave to RUN when cnt reaches 0 (after that cycle).
  - branch_taken here preempts the stall: go to FLUSH behaviour with cnt reloaded (or RUN when FLUSH_CYCLES = 1).
- FLUSH: if_id_flush = id_ex_bubble = 1; cnt decrements; go to RUN at 0.
- Reset: state RUN, cnt 0; every control output 0 and fwd selects 00.
  - Outputs are 0 while rst is high, even combinational ones.
  - A reset mid-stall or mid-flush aborts on the same edge.
- Latency: all stall/flush/forward outputs are valid in the same cycle as their inputs; no added registered latency.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds three 32-bit outputs, each cleared by rst and wrapping at 2^32:
  - perf_lu_stalls: cycles with the load-use stall asserted;
  - perf_flushes: cycles with if_id_flush asserted;
  - perf_mem_waits: cycles with pipe_hold asserted.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg:
  - FSM state encoding (RUN = 2'd0, LU_STALL = 2'd1, FLUSH = 2'd2, MEM_WAIT = 2'd3);
  - forwarding-select constants FWD_RF / FWD_EXMEM / FWD_MEMWB;
  - default REG_ADDR_W.
- One natural sub-module: forwarding_unit (purely combinational, instantiated once, producing both selects).

Test Plan:
- Load-use: lw x5 in EX (id_ex_mem_read = 1, rd = 5); ID add with rs1 = 5 and uses_rs1 = 1 → pc_stall = if_id_stall = id_ex_bubble = 1 for exactly LOAD_USE_STALL cycles (check 1 and 3). Repeat with rd = 0 → no stall.
- Forwarding: EX/MEM rd = 7 with write, MEM/WB rd = 7 with write, id_ex_rs1 = 7 → fwd_a_sel = 10. Drop the EX/MEM write → 01. Set rs2 = 0 with matching rd = 0 → fwd_b_sel = 00.
- Branch: branch_taken = 1 in RUN with FLUSH_CYCLES = 2 → if_id_flush and id_ex_bubble high for 2 cycles, then low. Concurrent lu_hit in the same cycle → pc_stall stays 0.
- Memory wait: ex_mem_mem_access = 1, dmem_ready = 0 for 4 cycles during LU_STALL (cnt = 2) → pipe_hold = 1 for 4 cycles, other outputs 0. After dmem_ready, the stall resumes with the remaining 2 cycles.
- Reset: assert rst mid-LU_STALL → on the next edge state is RUN and all outputs are 0. With HAZARD_PERF_CNT_EN, the counters read 0 after reset and perf_lu_stalls = 3 after a 3-cycle stall.
